// File: rtl/trap_controller.sv
// Trap controller: accepts an exception, flushes the pipeline, redirects to the
// handler, and on sret redirects back to the saved PC + 4.
module trap_controller #(
    parameter logic [14:0] TRAP_VECTOR  = 15'h1C00,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [14:0] sepc,
    input  logic [63:0] scause,
    input  logic        sret,
    output logic        flush,
    output logic        pc_redirect,
    output logic [14:0] redirect_pc,
    output logic [14:0] sepc_q,
    output logic [63:0] scause_q,
    output logic        in_trap,
    output logic        double_fault,
    output logic [7:0]  trap_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_RETURN
    } state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [14:0] sepc_n, redirect_pc_n;
    logic [63:0] scause_n;
    logic [7:0]  count_n;
    logic        double_fault_n;
    logic        flush_n, pc_redirect_n, in_trap_n;

    // Outputs are computed from the next state and registered, so no input
    // reaches an output without passing through a flop.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_n        = state;
        cnt_n          = cnt;
        sepc_n         = sepc_q;
        scause_n       = scause_q;
        count_n        = trap_count;
        double_fault_n = double_fault;
        redirect_pc_n  = redirect_pc;

        case (state)
            S_IDLE: begin
                if (exception) begin
                    sepc_n   = sepc;
                    scause_n = scause;
                    count_n  = (trap_count == 8'hFF) ? 8'hFF : trap_count + 8'd1;
                    cnt_n    = 3'd0;
                    state_n  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_n       = S_REDIRECT;
                    redirect_pc_n = TRAP_VECTOR;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            S_REDIRECT: state_n = S_HANDLER;
            S_HANDLER: begin
                if (sret) begin
                    state_n       = S_RETURN;
                    redirect_pc_n = sepc_q + 15'd4;
                end
            end
            S_RETURN: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        // A nested exception is never serviced; it only leaves a sticky mark.
        if (exception && state != S_IDLE) double_fault_n = 1'b1;

        flush_n       = (state_n == S_FLUSH) || (state_n == S_REDIRECT) || (state_n == S_RETURN);
        pc_redirect_n = (state_n == S_REDIRECT) || (state_n == S_RETURN);
        in_trap_n     = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 3'd0;
            flush        <= 1'b0;
            pc_redirect  <= 1'b0;
            redirect_pc  <= 15'd0;
            sepc_q       <= 15'd0;
            scause_q     <= 64'd0;
            in_trap      <= 1'b0;
            double_fault <= 1'b0;
            trap_count   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state        <= state_n;
            cnt          <= cnt_n;
            flush        <= flush_n;
            pc_redirect  <= pc_redirect_n;
            redirect_pc  <= redirect_pc_n;
            sepc_q       <= sepc_n;
            scause_q     <= scause_n;
            in_trap      <= in_trap_n;
            double_fault <= double_fault_n;
            trap_count   <= count_n;
        end
    end

endmodule
